// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon hash controller: FSM states, block geometry,
// mode encodings and the last-block test used by the controller.
package ascon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_PROC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned BLOCK_BYTES = 8;
  localparam int unsigned LEN_W       = 33;
  localparam int unsigned WORD_W      = 64;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned LAT_W       = 16;
  localparam int unsigned N_LANES     = 5;

  localparam logic [1:0] SEL_HASH  = 2'd0;
  localparam logic [1:0] SEL_HASHA = 2'd1;
  localparam logic [1:0] SEL_XOF   = 2'd2;
  localparam logic [1:0] SEL_XOFA  = 2'd3;

  localparam logic [LEN_W-1:0] BLOCK_INC  = {1'b0, BLOCK_BYTES};
  localparam logic [LEN_W:0]   BLOCK_INCW = {2'b00, BLOCK_BYTES};

  // One extra bit so that pos + 8 cannot wrap when msg_len is near 2^33-1.
  function automatic logic is_last_block(input logic [LEN_W-1:0] pos,
                                         input logic [LEN_W-1:0] len);
    logic [LEN_W:0] next_pos;
    next_pos = {1'b0, pos} + BLOCK_INCW;
    return next_pos > {1'b0, len};
  endfunction

endpackage

// File: rtl/ascon_hash_ctrl_if.sv
// Message word stream between a producer (master) and the hash controller (slave).
interface ascon_hash_ctrl_if;
  import ascon_pkg::*;

  logic [WORD_W-1:0] msg_data;
  logic              msg_valid;
  logic              msg_ready;

  modport master (output msg_data, output msg_valid, input msg_ready);
  modport slave  (input msg_data, input msg_valid, output msg_ready);

endinterface

// File: rtl/ascon_lat_cnt.sv
// Loadable down-counter used to time fixed-latency waits; zero is asserted
// while the count is exhausted, so a load of N-1 gives an N-cycle wait.
module ascon_lat_cnt
  import ascon_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Ascon hash job controller: sequences init, per-block fetch and absorb steps
// around external init/absorb datapaths and owns the x0..x4 state registers.
module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned INIT_LAT = 1,
  parameter int unsigned PROC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ascon_hash_ctrl_if.slave     msg,
  input  logic                 start,
  input  logic [1:0]           cfg_sel_type,
  input  logic [LEN_W-1:0]     msg_len,
  output logic [1:0]           sel_type,
  output logic                 process_en,
  output logic [LEN_W-1:0]     data_length,
  output logic [LEN_W-1:0]     data_position,
  output logic [BLOCK_W-1:0]   data,
  input  logic [WORD_W-1:0]    x0_init,
  input  logic [WORD_W-1:0]    x1_init,
  input  logic [WORD_W-1:0]    x2_init,
  input  logic [WORD_W-1:0]    x3_init,
  input  logic [WORD_W-1:0]    x4_init,
  output logic [WORD_W-1:0]    x0_i,
  output logic [WORD_W-1:0]    x1_i,
  output logic [WORD_W-1:0]    x2_i,
  output logic [WORD_W-1:0]    x3_i,
  output logic [WORD_W-1:0]    x4_i,
  input  logic [WORD_W-1:0]    x0_o,
  input  logic [WORD_W-1:0]    x1_o,
  input  logic [WORD_W-1:0]    x2_o,
  input  logic [WORD_W-1:0]    x3_o,
  input  logic [WORD_W-1:0]    x4_o,
  input  logic                 process_err,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Latencies of zero are treated as one cycle.
  localparam logic [LAT_W-1:0] INIT_LOAD = LAT_W'((INIT_LAT > 0) ? INIT_LAT - 1 : 0);
  localparam logic [LAT_W-1:0] PROC_LOAD = LAT_W'((PROC_LAT > 0) ? PROC_LAT - 1 : 0);

  state_t state_q;
  state_t state_d;

  logic [1:0]                      sel_q;
  logic [LEN_W-1:0]                len_q;
  logic [LEN_W-1:0]                pos_q;
  logic [WORD_W-1:0]               word_q;
  logic                            err_q;
  logic [N_LANES-1:0][WORD_W-1:0]  x_q;
  logic [N_LANES-1:0][WORD_W-1:0]  x_init_v;
  logic [N_LANES-1:0][WORD_W-1:0]  x_res_v;

  logic             cnt_load;
  logic [LAT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept_start;
  logic             load_init;
  logic             latch_word;
  logic             capture;
  logic             adv_pos;
  logic             set_err;

  ascon_lat_cnt #(
    .W (LAT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign x_init_v = {x4_init, x3_init, x2_init, x1_init, x0_init};
  assign x_res_v  = {x4_o, x3_o, x2_o, x1_o, x0_o};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    accept_start  = 1'b0;
    load_init     = 1'b0;
    latch_word    = 1'b0;
    capture       = 1'b0;
    adv_pos       = 1'b0;
    set_err       = 1'b0;
    busy          = (state_q != ST_IDLE);
    done          = 1'b0;
    msg.msg_ready = 1'b0;
    process_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          cnt_load     = 1'b1;
          cnt_val      = INIT_LOAD;
          state_d      = ST_INIT;
        end
      end
      ST_INIT: begin
        if (cnt_zero) begin
          load_init = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        msg.msg_ready = 1'b1;
        if (msg.msg_valid) begin
          latch_word = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = PROC_LOAD;
          state_d    = ST_PROC;
        end
      end
      ST_PROC: begin
        process_en = 1'b1;
        // A datapath error aborts the job and leaves the previous state intact.
        if (process_err) begin
          set_err = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_zero) begin
          capture = 1'b1;
          if (is_last_block(pos_q, len_q)) begin
            state_d = ST_DONE;
          end else begin
            adv_pos = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      len_q <= '0;
    end else if (accept_start) begin
      sel_q <= cfg_sel_type;
      len_q <= msg_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else if (accept_start) begin
      pos_q <= '0;
    end else if (adv_pos) begin
      pos_q <= pos_q + BLOCK_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (latch_word) begin
      word_q <= msg.msg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_start) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  // State survives job end so the final hash state stays visible until the next init.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
    end else if (load_init) begin
      x_q <= x_init_v;
    end else if (capture) begin
      x_q <= x_res_v;
    end
  end

  assign sel_type      = sel_q;
  assign data_length   = len_q;
  assign data_position = pos_q;
  assign data          = {{(BLOCK_W-WORD_W){1'b0}}, word_q};
  assign err           = err_q;
  assign x0_i          = x_q[0];
  assign x1_i          = x_q[1];
  assign x2_i          = x_q[2];
  assign x3_i          = x_q[3];
  assign x4_i          = x_q[4];

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Scoreboard bench for ascon_hash_ctrl with behavioural stand-ins for the
// external init and absorb datapaths.
module tb_ascon_hash_ctrl;
  import ascon_pkg::*;

  localparam int unsigned INIT_LAT = 1;
  localparam int unsigned PROC_LAT = 1;

  typedef logic [4:0][63:0] st_t;
  typedef struct packed {
    logic [32:0] pos;
    logic [63:0] data;
    logic [32:0] len;
    logic [1:0]  sel;
    st_t         x;
  } blk_t;
  typedef struct packed {
    logic err;
    st_t  x;
  } done_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start;
  logic [1:0]   cfg_sel_type;
  logic [32:0]  msg_len;
  logic [1:0]   sel_type;
  logic         process_en;
  logic [32:0]  data_length;
  logic [32:0]  data_position;
  logic [127:0] data;
  logic [63:0]  x0_init, x1_init, x2_init, x3_init, x4_init;
  logic [63:0]  x0_i, x1_i, x2_i, x3_i, x4_i;
  logic [63:0]  x0_o, x1_o, x2_o, x3_o, x4_o;
  logic         process_err;
  logic         busy, done, err;

  ascon_hash_ctrl_if msg_if ();

  ascon_hash_ctrl #(
    .INIT_LAT (INIT_LAT),
    .PROC_LAT (PROC_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .msg (msg_if),
    .start (start), .cfg_sel_type (cfg_sel_type), .msg_len (msg_len),
    .sel_type (sel_type), .process_en (process_en),
    .data_length (data_length), .data_position (data_position), .data (data),
    .x0_init (x0_init), .x1_init (x1_init), .x2_init (x2_init), .x3_init (x3_init), .x4_init (x4_init),
    .x0_i (x0_i), .x1_i (x1_i), .x2_i (x2_i), .x3_i (x3_i), .x4_i (x4_i),
    .x0_o (x0_o), .x1_o (x1_o), .x2_o (x2_o), .x3_o (x3_o), .x4_o (x4_o),
    .process_err (process_err), .busy (busy), .done (done), .err (err)
  );

  // Stand-in init datapath: Ascon-Hash IV lanes with the mode folded into x4.
  function automatic st_t mock_init(input logic [1:0] sel);
    st_t s;
    s[0] = 64'hee9398aadb67f03d;
    s[1] = 64'h8bb21831c60f1002;
    s[2] = 64'hb48a92db98d5da62;
    s[3] = 64'h43189921b8f8e3e8;
    s[4] = 64'h348fa5c9d525e140 ^ {62'd0, sel};
    return s;
  endfunction

  // Stand-in absorb datapath: any mixing that depends on every input will do.
  function automatic st_t mock_absorb(input st_t s, input logic [63:0] d,
                                      input logic [32:0] pos, input logic [32:0] len);
    st_t r;
    r[0] = s[0] ^ d ^ {31'd0, pos};
    r[1] = {s[1][50:0], s[1][63:51]} ^ r[0];
    r[2] = s[2] + s[1];
    r[3] = ~s[3] ^ s[4];
    r[4] = s[4] ^ {s[0][31:0], s[0][63:32]} ^ {31'd0, len};
    return r;
  endfunction

  st_t init_v, xi_v, xo_v;
  logic        err_arm = 1'b0;
  logic [32:0] err_pos = '0;

  assign xi_v = {x4_i, x3_i, x2_i, x1_i, x0_i};
  always_comb init_v = mock_init(sel_type);
  always_comb xo_v = mock_absorb(xi_v, data[63:0], data_position, data_length);
  assign {x4_init, x3_init, x2_init, x1_init, x0_init} = init_v;
  assign {x4_o, x3_o, x2_o, x1_o, x0_o} = xo_v;
  assign process_err = err_arm & process_en & (data_position == err_pos);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation pending (t=%0t)", name, $time);
  endtask

  blk_t  exp_blk[$];
  done_t exp_done[$];
  logic [63:0] job_words [16];

  // Reference model: one block per 8-byte slot including the slot that holds
  // the padding, folded through the stand-in datapath; an error drops the block.
  task automatic push_job(input logic [32:0] len, input logic [1:0] sel);
    st_t s;
    int  nblk;
    done_t d;
    s = mock_init(sel);
    nblk = int'(len / 8) + 1;
    for (int i = 0; i < nblk; i++) begin
      blk_t b;
      b.pos = 33'(i * 8);
      b.data = job_words[i];
      b.len = len;
      b.sel = sel;
      b.x = s;
      exp_blk.push_back(b);
      if (err_arm && b.pos == err_pos) begin
        d.err = 1'b1;
        d.x = s;
        exp_done.push_back(d);
        return;
      end
      s = mock_absorb(s, job_words[i], b.pos, len);
    end
    d.err = 1'b0;
    d.x = s;
    exp_done.push_back(d);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) job_words[i] = {$urandom, $urandom};
  endtask

  task automatic fill_text();
    string s;
    s = "This is my test for processing associated data";
    for (int i = 0; i < 16; i++) job_words[i] = '0;
    for (int b = 0; b < s.len(); b++) job_words[b / 8][8 * (b % 8) +: 8] = s[b];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, err, msg_if.msg_ready, process_en}, '0);
    check({tag, "_cfg"}, {sel_type, data_length, data_position}, '0);
    check({tag, "_data"}, data, '0);
    check({tag, "_state"}, xi_v, '0);
  endtask

  task automatic run_job(input logic [32:0] len, input logic [1:0] sel,
                         input int stall_before, input int stall_cycles, input bit hold_start);
    int nblk;
    int n;
    nblk = int'(len / 8) + 1;
    push_job(len, sel);
    @(negedge clk);
    start = 1'b1;
    cfg_sel_type = sel;
    msg_len = len;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check("err_clr_on_start", err, 1'b0);
    for (int w = 0; w < nblk; w++) begin
      if (w == stall_before && stall_cycles > 0) begin
        repeat (stall_cycles) @(negedge clk);
        if (w > 0 && stall_cycles >= int'(PROC_LAT) && busy)
          check("stall_hold", {msg_if.msg_ready, process_en}, 2'b10);
      end
      msg_if.msg_valid = 1'b1;
      msg_if.msg_data = job_words[w];
      n = 0;
      while (!msg_if.msg_ready && busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!busy) begin
        msg_if.msg_valid = 1'b0;
        break;
      end
      if (n >= 200) begin
        check("fetch_timeout", 1'b1, 1'b0);
        msg_if.msg_valid = 1'b0;
        break;
      end
      @(negedge clk);
      msg_if.msg_valid = 1'b0;
      msg_if.msg_data = {$urandom, $urandom};
    end
    n = 0;
    while (busy && n < 500) begin
      if (done && hold_start) start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("done_timeout", 1'b1, 1'b0);
    start = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts a block or ends a job.
  blk_t  cur;
  done_t dexp;
  logic  pen_q = 1'b0, done_q = 1'b0, busy_q = 1'b0;
  int    run_len = 0;
  bit    run_err = 1'b0;
  bit    in_init = 1'b0;
  int    init_cycles = 0;
  int    job_starts = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pen_q = 1'b0; done_q = 1'b0; busy_q = 1'b0; in_init = 1'b0; run_len = 0;
    end else begin
      check("ready_en_excl", msg_if.msg_ready & process_en, 1'b0);
      if (busy && !busy_q) begin
        job_starts++;
        in_init = 1'b1;
        init_cycles = 0;
      end
      if (in_init) begin
        if (msg_if.msg_ready) begin
          check("init_lat", init_cycles, INIT_LAT);
          in_init = 1'b0;
        end else begin
          init_cycles++;
        end
      end
      if (process_en) begin
        if (!pen_q) begin
          if (exp_blk.size() == 0) fail("blk_unexpected");
          else cur = exp_blk.pop_front();
          run_len = 0;
          run_err = 1'b0;
        end
        run_len++;
        run_err |= process_err;
        check("blk_pos", data_position, cur.pos);
        check("blk_data", data, {64'd0, cur.data});
        check("blk_len", data_length, cur.len);
        check("blk_sel", sel_type, cur.sel);
        check("blk_state", xi_v, cur.x);
      end else if (pen_q && !run_err) begin
        check("proc_lat", run_len, PROC_LAT);
      end
      if (done) begin
        if (done_q) fail("done_width");
        else if (exp_done.size() == 0) fail("done_unexpected");
        else begin
          dexp = exp_done.pop_front();
          check("done_err", err, dexp.err);
          check("done_state", xi_v, dexp.x);
        end
      end
      pen_q = process_en;
      done_q = done;
      busy_q = busy;
    end
  end

  logic        rst_arm = 1'b0;
  logic [32:0] rst_pos = '0;

  always @(negedge clk) begin
    if (rst_arm && process_en && data_position == rst_pos) begin
      rst_arm = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midjob_rst");
      exp_blk.delete();
      exp_done.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int n;
    int len;
    start = 1'b0;
    cfg_sel_type = '0;
    msg_len = '0;
    msg_if.msg_valid = 1'b0;
    msg_if.msg_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, msg_if.msg_ready, process_en}, 3'b000);

    fill_text();
    run_job(33'd62, SEL_HASH, -1, 0, 1'b0);
    check("text_err", err, 1'b0);

    fill_rand();
    run_job(33'd0, SEL_HASHA, -1, 0, 1'b0);

    fill_rand();
    run_job(33'd16, SEL_XOF, 1, 5, 1'b0);

    fill_rand();
    err_arm = 1'b1;
    err_pos = 33'd16;
    run_job(33'd40, SEL_XOFA, -1, 0, 1'b0);
    err_arm = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1'b1);
    fill_rand();
    run_job(33'd8, SEL_HASH, -1, 0, 1'b0);
    check("err_cleared", err, 1'b0);

    fill_rand();
    rst_arm = 1'b1;
    rst_pos = 33'd24;
    run_job(33'd40, SEL_XOF, -1, 0, 1'b0);
    n = 0;
    while (!rst_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("rst_abandoned", {busy, done}, 2'b00);
    fill_rand();
    run_job(33'd8, SEL_HASHA, -1, 0, 1'b0);

    fill_rand();
    s0 = job_starts;
    run_job(33'd24, SEL_HASH, -1, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("held_start_one_job", job_starts - s0, 1);
    check("held_start_idle", busy, 1'b0);

    for (int j = 0; j < 10; j++) begin
      fill_rand();
      len = $urandom_range(0, 100);
      run_job(33'(len), 2'($urandom_range(0, 3)), $urandom_range(0, len / 8),
              $urandom_range(0, 4), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("sb_blocks_left", exp_blk.size(), 0);
    check("sb_done_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
